simple_processor_param: RTL
===========================

# simple_processor_param

Parametrised successor of the 9-bit multicycle simple processor: eight general registers of `DATA_W` bits, a shared `Bus`, and an instruction word fetched from `DIN` under `Run`. It extends the original mv/mvi/add/sub set with logic ops, a conditional move, zero/carry flags and an illegal-opcode indication. It sits at the same level as `simple_processor_Top` and is driven by the same style of bench, with DIN sequencing.

## Interface
- `DATA_W`, default 16: register, `DIN` and `Bus` width. Legal range is 9..32.
- `Clock`  in  1: single clock, rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `Run`  in  1: fetch enable, sampled only in state T0.
- `DIN`  in  `DATA_W`: instruction in T0 (`DIN[8:0]` = III XXX YYY, upper bits ignored); immediate word in T1 of mvi.
- `Bus`  out  `DATA_W`: shared datapath bus.
- `Done`  out  1: high in the final cycle of every instruction.
- `Err`  out  1: high together with `Done` for an illegal opcode.
- `Zflag`  out  1: registered zero flag.
- `Cflag`  out  1: registered carry/borrow flag.

## Operation
- Registers: R0..R7, IR (9 bits), A, G (`DATA_W`), Z, C, 2-bit state (T0..T3).
- Opcodes (III):
  - 000 mv: Rx←Ry.
  - 001 mvi: Rx←DIN.
  - 010 add: Rx←Rx+Ry.
  - 011 sub: Rx←Rx−Ry.
  - 100 and.
  - 101 or.
  - 110 mvnz: Rx←Ry only if Z=0.
  - 111 illegal.
- T0: `Bus`=0, `Done`=0. If `Run`=1, IR←`DIN[8:0]` and go to T1; otherwise stay in T0.
- T1 for mv and mvnz: `Bus`=Ry, `Done`=1, Rx written at the edge (mvnz writes only when Z=0); then T0.
- T1 for mvi: `Bus`=`DIN`, `Done`=1, Rx←`DIN`; then T0.
- T1 for add/sub/and/or: `Bus`=Rx, A←`Bus`; then T2.
- T2: `Bus`=Ry, G←A op `Bus`, Z and C updated at the same edge; then T3.
- T3: `Bus`=G, Rx←G, `Done`=1; then T0.
- T1 for 111: `Bus`=0, `Done`=1, `Err`=1, no register or flag write; then T0.
- Arithmetic is modulo 2^`DATA_W`.
  - add: C = carry-out.
  - sub: C=1 when Rx<Ry unsigned (borrow).
  - and/or: C=0.
  - Z = (result == 0).
- mv, mvi and mvnz leave Z and C unchanged.
- Rx may equal Ry for every opcode. Example: add R1,R1 doubles R1.
- `Run` is ignored in T1..T3. An instruction always completes once fetched.

## Timing
- Reset (asynchronous, immediate) clears R0..R7, IR, A, G, Z and C, and forces T0. Consequently `Bus`=0, `Done`=0, `Err`=0, `Zflag`=0, `Cflag`=0.
- `Done`, `Err` and `Bus` are combinational decodes of state and IR. `Zflag` and `Cflag` are register outputs.
- Latency from the fetch edge:
  - mv, mvi, mvnz and illegal: `Done` in the next cycle (2 cycles per instruction including T0).
  - ALU ops: `Done` in the 3rd cycle after fetch (4 cycles per instruction).
- The mvi immediate must be on `DIN` during the T1 cycle, i.e. one cycle after the instruction word.
- Back-to-back: with `Run` held at 1, the next fetch happens in the T0 immediately after `Done`. There is no idle cycle beyond T0.
- Reset mid-instruction (T1..T3) aborts with no Rx write. The flag-register clear takes precedence over any pending T2 flag update.
- `Done` is high for exactly one cycle per fetched instruction.

## Test plan
- `DATA_W`=16, Reset, then fetch 9'b001_000_000 with `DIN`=16'h1234 in T1. Required: `Bus`=1234 and `Done`=1 in T1, then R0=1234. Then mv R5,R0: `Bus`=1234 in T1.
- R1=FFFF, R2=0001; add R1,R2. Required: `Bus`=FFFF in T1, 0001 in T2, 0000 in T3 with `Done`=1. Afterwards R1=0000, `Zflag`=1, `Cflag`=1.
- R3=0005, R4=0007; sub R3,R4. Required: R3=FFFE, `Cflag`=1, `Zflag`=0. Then and R3,R4: R3=0006, `Cflag`=0.
- Set Z=1 via sub R0,R0, then mvnz R6,R2: R6 unchanged while `Done` still pulses. Set Z=0 via or with a nonzero value, then mvnz R6,R2: R6=R2.
- Fetch opcode 111: `Done`=`Err`=1 for one cycle, all registers and flags unchanged. Hold `Run`=0: the block stays in T0 with `Bus`=0 and `Done`=0 indefinitely.
- Assert `Reset` during T2 of add R1,R2. Required: all outputs 0 immediately. After release, mv R7,R1 shows `Bus`=0000.

Source files
------------

// File: rtl/simple_processor_param.sv
// Parametrised multicycle processor: eight DATA_W-bit registers on a shared bus, with
// mv/mvi/add/sub/and/or/mvnz, registered zero/carry flags and an illegal-opcode strobe.
module simple_processor_param #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] Bus,
  output logic              Done,
  output logic              Err,
  output logic              Zflag,
  output logic              Cflag
);

  typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_e;

  localparam logic [2:0] OpMv   = 3'b000;
  localparam logic [2:0] OpMvi  = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpOr   = 3'b101;
  localparam logic [2:0] OpMvnz = 3'b110;
  localparam logic [2:0] OpIll  = 3'b111;

  state_e            state_q;
  logic [8:0]        ir_q;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] a_q, g_q;
  logic              z_q, c_q;

  logic [2:0]        op, rx, ry;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  assign op    = ir_q[8:6];
  assign rx    = ir_q[5:3];
  assign ry    = ir_q[2:0];
  assign Zflag = z_q;
  assign Cflag = c_q;

  always_comb begin
    Bus  = '0;
    Done = 1'b0;
    Err  = 1'b0;
    unique case (state_q)
      StT0: ;
      StT1: begin
        case (op)
          OpMv, OpMvnz: begin
            Bus  = regs_q[ry];
            Done = 1'b1;
          end
          OpMvi: begin
            Bus  = DIN;
            Done = 1'b1;
          end
          OpIll: begin
            Done = 1'b1;
            Err  = 1'b1;
          end
          default: Bus = regs_q[rx];
        endcase
      end
      StT2: Bus = regs_q[ry];
      StT3: begin
        Bus  = g_q;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU sees A and the bus, which carries Ry during T2.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, Bus};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OpAdd: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OpSub: begin
        alu_res = a_q - Bus;
        alu_c   = (a_q < Bus);
      end
      OpAnd:   alu_res = a_q & Bus;
      OpOr:    alu_res = a_q | Bus;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StT0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StT0: begin
          if (Run) begin
            ir_q    <= DIN[8:0];
            state_q <= StT1;
          end
        end
        StT1: begin
          case (op)
            OpMv, OpMvi: begin
              regs_q[rx] <= Bus;
              state_q    <= StT0;
            end
            OpMvnz: begin
              if (!z_q) regs_q[rx] <= Bus;
              state_q <= StT0;
            end
            OpIll: state_q <= StT0;
            default: begin
              a_q     <= Bus;
              state_q <= StT2;
            end
          endcase
        end
        StT2: begin
          g_q     <= alu_res;
          z_q     <= (alu_res == '0);
          c_q     <= alu_c;
          state_q <= StT3;
        end
        StT3: begin
          regs_q[rx] <= g_q;
          state_q    <= StT0;
        end
        default: state_q <= StT0;
      endcase
    end
  end

endmodule
